// File: rtl/pf_word_packer.sv
// Packs the 16-bit write stream into 48-bit FIFO entries: three words per entry in ECC mode, one word per entry otherwise.
// Define PF_DROP_CNT_EN to add the saturating DROP_CNT output that counts entries dropped on FF_FULL.
module pf_word_packer #(
  parameter logic [15:0] PAD_WORD = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] DIN,
  input  logic        DIN_VLD,
  input  logic        ECC,
  input  logic        FLUSH,
  input  logic        FF_FULL,
  output logic [47:0] FFWRD,
  output logic        WR_EN,
  output logic [1:0]  WCNT,
`ifdef PF_DROP_CNT_EN
  output logic [7:0]  DROP_CNT,
`endif
  output logic        OVFL
);

  // state  | meaning
  // WRD_0  | empty; ECC sampled here, non-ECC words pass straight through
  // WRD_1  | word0 held in hold[15:0]
  // WRD_2  | word0/word1 held in hold[31:0]
  localparam logic [1:0] WRD_0 = 2'd0;
  localparam logic [1:0] WRD_1 = 2'd1;
  localparam logic [1:0] WRD_2 = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] hold;
  logic [31:0] hold_nxt;
  logic        commit;
  logic [47:0] entry;

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    commit    = 1'b0;
    entry     = 48'h0;
    case (state)
      WRD_0: begin
        if (DIN_VLD) begin
          if (!ECC) begin
            commit = 1'b1;
            entry  = {32'h0, DIN};
          end else if (FLUSH) begin
            commit = 1'b1;
            entry  = {PAD_WORD, PAD_WORD, DIN};
          end else begin
            hold_nxt[15:0] = DIN;
            state_nxt      = WRD_1;
          end
        end
      end
      WRD_1: begin
        if (DIN_VLD && FLUSH) begin
          commit    = 1'b1;
          entry     = {PAD_WORD, DIN, hold[15:0]};
          state_nxt = WRD_0;
        end else if (DIN_VLD) begin
          hold_nxt[31:16] = DIN;
          state_nxt       = WRD_2;
        end else if (FLUSH) begin
          commit    = 1'b1;
          entry     = {PAD_WORD, PAD_WORD, hold[15:0]};
          state_nxt = WRD_0;
        end
      end
      WRD_2: begin
        // a completing word always wins over FLUSH, so only one entry goes out
        if (DIN_VLD) begin
          commit    = 1'b1;
          entry     = {DIN, hold};
          state_nxt = WRD_0;
        end else if (FLUSH) begin
          commit    = 1'b1;
          entry     = {PAD_WORD, hold};
          state_nxt = WRD_0;
        end
      end
      default: begin
        state_nxt = WRD_0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= WRD_0;
      hold  <= 32'h0;
      FFWRD <= 48'h0;
      WR_EN <= 1'b0;
      OVFL  <= 1'b0;
    end else begin
      state <= state_nxt;
      hold  <= hold_nxt;
      WR_EN <= commit && !FF_FULL;
      if (commit && !FF_FULL) begin
        FFWRD <= entry;
      end
      if (commit && FF_FULL) begin
        OVFL <= 1'b1;
      end
    end
  end

`ifdef PF_DROP_CNT_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      DROP_CNT <= 8'h00;
    end else if (commit && FF_FULL && (DROP_CNT != 8'hFF)) begin
      DROP_CNT <= DROP_CNT + 8'h01;
    end
  end
`endif

  assign WCNT = state;

endmodule

// File: tb/tb_pf_word_packer.sv
// Directed bench for pf_word_packer (PAD_WORD = 16'hFFFF); DROP_CNT checked when PF_DROP_CNT_EN is defined.
module tb_pf_word_packer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] DIN;
  logic        DIN_VLD;
  logic        ECC;
  logic        FLUSH;
  logic        FF_FULL;
  logic [47:0] FFWRD;
  logic        WR_EN;
  logic [1:0]  WCNT;
  logic        OVFL;
`ifdef PF_DROP_CNT_EN
  logic [7:0]  DROP_CNT;
`endif

  int passed = 0;
  int total  = 0;

  pf_word_packer #(.PAD_WORD(16'hFFFF)) dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VLD(DIN_VLD), .ECC(ECC),
    .FLUSH(FLUSH), .FF_FULL(FF_FULL), .FFWRD(FFWRD), .WR_EN(WR_EN),
    .WCNT(WCNT),
`ifdef PF_DROP_CNT_EN
    .DROP_CNT(DROP_CNT),
`endif
    .OVFL(OVFL)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic word(input logic [15:0] d);
    DIN     = d;
    DIN_VLD = 1'b1;
    tick();
    DIN_VLD = 1'b0;
  endtask

  initial begin
    RST = 1'b1; DIN = 16'h0; DIN_VLD = 1'b0; ECC = 1'b0; FLUSH = 1'b0; FF_FULL = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_wr_en", 48'(WR_EN), 48'd0);
    chk("rst_wcnt", 48'(WCNT), 48'd0);
    chk("rst_ovfl", 48'(OVFL), 48'd0);
    chk("rst_ffwrd", FFWRD, 48'h0);

    // three-word ECC entry
    ECC = 1'b1;
    word(16'h1111);
    chk("ecc_wcnt1", 48'(WCNT), 48'd1);
    chk("ecc_wr_en_a", 48'(WR_EN), 48'd0);
    word(16'h2222);
    chk("ecc_wcnt2", 48'(WCNT), 48'd2);
    chk("ecc_wr_en_b", 48'(WR_EN), 48'd0);
    word(16'h3333);
    chk("ecc_wcnt0", 48'(WCNT), 48'd0);
    chk("ecc_wr_en", 48'(WR_EN), 48'd1);
    chk("ecc_ffwrd", FFWRD, 48'h333322221111);
    tick();
    chk("ecc_wr_en_off", 48'(WR_EN), 48'd0);
    chk("ecc_ffwrd_hold", FFWRD, 48'h333322221111);

    // non-ECC back-to-back
    ECC = 1'b0;
    DIN = 16'hABCD; DIN_VLD = 1'b1;
    tick();
    chk("necc_wr_en_a", 48'(WR_EN), 48'd1);
    chk("necc_ffwrd_a", FFWRD, 48'h00000000ABCD);
    DIN = 16'h1234;
    tick();
    DIN_VLD = 1'b0;
    chk("necc_wr_en_b", 48'(WR_EN), 48'd1);
    chk("necc_ffwrd_b", FFWRD, 48'h000000001234);
    chk("necc_wcnt", 48'(WCNT), 48'd0);
    tick();
    chk("necc_wr_en_off", 48'(WR_EN), 48'd0);

    // flush with one word held
    ECC = 1'b1;
    word(16'h5555);
    tick();
    chk("fl1_wcnt_held", 48'(WCNT), 48'd1);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("fl1_wr_en", 48'(WR_EN), 48'd1);
    chk("fl1_ffwrd", FFWRD, 48'hFFFFFFFF5555);
    chk("fl1_wcnt", 48'(WCNT), 48'd0);
    tick();
    chk("fl1_wr_en_single", 48'(WR_EN), 48'd0);

    // flush in Wrd_0 does nothing
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("fl0_wr_en", 48'(WR_EN), 48'd0);
    chk("fl0_wcnt", 48'(WCNT), 48'd0);

    // flush with two words held
    word(16'hF001);
    word(16'hF002);
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    chk("fl2_wr_en", 48'(WR_EN), 48'd1);
    chk("fl2_ffwrd", FFWRD, 48'hFFFFF002F001);

    // drop on FF_FULL
    word(16'h0A01);
    word(16'h0A02);
    FF_FULL = 1'b1;
    word(16'h0A03);
    FF_FULL = 1'b0;
    chk("drop_wr_en", 48'(WR_EN), 48'd0);
    chk("drop_ovfl", 48'(OVFL), 48'd1);
    chk("drop_wcnt", 48'(WCNT), 48'd0);
    chk("drop_ffwrd_hold", FFWRD, 48'hFFFFF002F001);
`ifdef PF_DROP_CNT_EN
    chk("drop_cnt", 48'(DROP_CNT), 48'd1);
`endif
    word(16'hB001);
    word(16'hB002);
    word(16'hB003);
    chk("post_drop_wr_en", 48'(WR_EN), 48'd1);
    chk("post_drop_ffwrd", FFWRD, 48'hB003B002B001);
    chk("ovfl_sticky", 48'(OVFL), 48'd1);

    // ECC ignored mid-entry
    word(16'hC001);
    ECC = 1'b0;
    word(16'h7777);
    chk("mode_wcnt2", 48'(WCNT), 48'd2);
    chk("mode_no_wr", 48'(WR_EN), 48'd0);
    word(16'hC003);
    chk("mode_wr_en", 48'(WR_EN), 48'd1);
    chk("mode_ffwrd", FFWRD, 48'hC0037777C001);
    word(16'h0042);
    chk("mode_resume_wr_en", 48'(WR_EN), 48'd1);
    chk("mode_resume_ffwrd", FFWRD, 48'h000000000042);

    // reset mid-entry
    ECC = 1'b1;
    word(16'hD001);
    word(16'hD002);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_mid_wr_en", 48'(WR_EN), 48'd0);
    chk("rst_mid_wcnt", 48'(WCNT), 48'd0);
    chk("rst_mid_ffwrd", FFWRD, 48'h0);
    chk("rst_mid_ovfl", 48'(OVFL), 48'd0);
`ifdef PF_DROP_CNT_EN
    chk("rst_mid_drop_cnt", 48'(DROP_CNT), 48'd0);
`endif
    tick();
    chk("rst_mid_no_late_wr", 48'(WR_EN), 48'd0);
    word(16'hE001);
    word(16'hE002);
    word(16'hE003);
    chk("fresh_wr_en", 48'(WR_EN), 48'd1);
    chk("fresh_ffwrd", FFWRD, 48'hE003E002E001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pf_word_packer.md
Name: pf_word_packer

Overview:
- Write-side stage directly upstream of the pipeline-FIFO read FSM.
- Accepts the 16-bit data stream and produces the 48-bit FIFO entries that the read FSM later unpacks.
- ECC mode: packs three consecutive 16-bit words into one 48-bit entry (word0 in [15:0], word1 in [31:16], word2 in [47:32]).
- Non-ECC mode: writes one 16-bit word per entry in [15:0], upper 32 bits zero, matching the reader's No_ECC 1:1 read pattern.

Parameters:
PAD_WORD, 16'h0000, fill value for unused slots when a partial ECC entry is flushed.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous, active-high reset.
DIN  input  16  incoming data word.
DIN_VLD  input  1  DIN valid this cycle; one word accepted per asserted cycle, no back-pressure.
ECC  input  1  1 = pack 3 words per entry; 0 = 1 word per entry.
FLUSH  input  1  single-cycle request to write out a partially filled ECC entry.
FF_FULL  input  1  downstream FIFO full flag.
FFWRD  output  48  FIFO write data (registered).
WR_EN  output  1  FIFO write strobe (registered, one cycle per entry).
WCNT  output  2  words currently held in the partial entry (0..2).
OVFL  output  1  sticky: an entry was dropped because FF_FULL was high.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. On a RST edge, all of the following are cleared: state becomes Wrd_0, FFWRD = 0, WR_EN = 0, WCNT = 0, OVFL = 0, and the holding register is cleared.
- RST asserted mid-entry discards the held words; no write is produced.
- States: Wrd_0 (empty), Wrd_1 (one word held), Wrd_2 (two words held).
  - WCNT equals the state index.
  - No separate non-ECC state: non-ECC traffic passes through Wrd_0.
- Mode sampling: ECC is sampled only in Wrd_0. In Wrd_1 and Wrd_2 it is ignored until the entry completes or is flushed.
- Wrd_0, ECC = 0, DIN_VLD = 1: entry {32'h0, DIN} is committed; stay in Wrd_0.
- Wrd_0, ECC = 1, DIN_VLD = 1: hold[15:0] = DIN; go to Wrd_1.
- Wrd_1, DIN_VLD = 1: hold[31:16] = DIN; go to Wrd_2.
- Wrd_2, DIN_VLD = 1: entry {DIN, hold[31:0]} is committed; go to Wrd_0.
- No DIN_VLD: the state holds.
- FLUSH in Wrd_1/Wrd_2 with no completing word:
  - Empty slots are filled with PAD_WORD.
  - The padded entry is committed.
  - The state goes to Wrd_0.
- FLUSH in Wrd_0: ignored.
- FLUSH together with DIN_VLD:
  - DIN is placed first.
  - If that completes the entry, it is committed normally.
  - Otherwise the remaining slots are padded and committed.
  - In every case the state goes to Wrd_0, and exactly one entry is committed.
- Commit rule, evaluated on the edge where the entry completes:
  - FF_FULL = 0: FFWRD takes the entry and WR_EN = 1 for exactly the following cycle. Latency is 1 cycle from the completing DIN_VLD/FLUSH edge to WR_EN.
  - FF_FULL = 1: entry dropped, WR_EN stays 0, OVFL set to 1. OVFL is cleared only by RST.
- WR_EN is 0 in all cycles with no commit. FFWRD holds its last value when WR_EN = 0.
- Back-to-back: non-ECC DIN_VLD on consecutive cycles gives WR_EN on consecutive cycles, full rate.
- Illegal state encoding returns to Wrd_0 on the next edge with WR_EN = 0.

Optional Feature:
PF_DROP_CNT_EN
- Defined: adds output DROP_CNT[7:0]. It increments on each dropped entry and saturates at 8'hFF. RST clears it.
- Undefined: the port and counter are absent; OVFL alone reports drops.

Test Plan:
- RST, then ECC = 1, DIN = 16'h1111, 16'h2222, 16'h3333 on 3 consecutive cycles, FF_FULL = 0 -> WR_EN = 1 for one cycle, 1 cycle after the third word; FFWRD = 48'h333322221111; WCNT sequence 1, 2, 0.
- ECC = 0, DIN = 16'hABCD then 16'h1234 back-to-back -> two consecutive WR_EN pulses; FFWRD = 48'h00000000ABCD then 48'h000000001234.
- ECC = 1, PAD_WORD = 16'hFFFF, DIN = 16'h5555, then FLUSH two cycles later -> single WR_EN; FFWRD = 48'hFFFFFFFF5555; WCNT returns to 0.
- ECC = 1, two words held, third word arrives with FF_FULL = 1 -> no WR_EN; OVFL = 1 and remains 1; with PF_DROP_CNT_EN, DROP_CNT = 1. Next 3 words with FF_FULL = 0 -> normal write.
- ECC = 1, one word held, ECC driven 0 and DIN = 16'h7777 valid -> word packed as word1 (WCNT = 2), no write. After a third word the entry is written; then non-ECC 1:1 writes resume.
- Two words held, RST asserted for one cycle -> no WR_EN; WCNT = 0; FFWRD = 0; OVFL = 0.
